alu_seq_ctrl: RTL and testbench

Command sequencer for the shared 16-bit ALU: x/y inputs, control bits zx/nx/zy/ny/f/no, output o with zr/ng flags. It accepts one command at a time over a valid/ready handshake and drives the ALU operands and control bits. Single-op commands finish in one ALU cycle. MUL is a 16-iteration shift-and-add loop that reuses the same ALU adder. It sits between the CPU decode/issue logic and the combinational ALU, so the ALU needs no multiplier of its own.

---
 rtl/alu_seq_ctrl_if.sv | 44 ++++
 rtl/alu_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Bundle of command, response and ALU-side signals for the ALU sequencer.
// The master modport is the issuer/ALU environment; slave is the sequencer.
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zx;
    logic             alu_nx;
    logic             alu_zy;
    logic             alu_ny;
    logic             alu_f;
    logic             alu_no;
    logic [WIDTH-1:0] alu_o;
    logic             alu_zr;
    logic             alu_ng;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zr;
    logic             rsp_ng;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output alu_o, alu_zr, alu_ng,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err,
        input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  alu_o, alu_zr, alu_ng,
        output cmd_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err,
        output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the shared 16-bit ALU. Single ops take one ALU
// cycle; MUL runs a fixed 16-step shift-and-add through the same ALU adder.
module alu_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16
) (
    input logic          clk,
    input logic          rst_n,
    alu_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_PASSA = 3'b100,
        OP_MUL   = 3'b101
    } op_t;

    state_t           state, state_nx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zr_q, rsp_ng_q, rsp_err_q;
    logic [5:0]       ctl;
    logic             cmd_illegal;

    assign cmd_illegal   = (bus.cmd_op[2:1] == 2'b11);
    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zr    = rsp_zr_q;
    assign bus.rsp_ng    = rsp_ng_q;
    assign bus.rsp_err   = rsp_err_q;
    assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = ctl;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and ALU operand/control drive.
    always_comb begin
        state_nx  = state;
        ctl       = '0;
        bus.alu_x = '0;
        bus.alu_y = '0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_illegal)                state_nx = DONE;
                    else if (bus.cmd_op == OP_MUL)  state_nx = MUL;
                    else                            state_nx = EXEC;
                end
            end
            EXEC: begin
                bus.alu_x = a_q;
                bus.alu_y = b_q;
                case (op_q)
                    OP_ADD:   ctl = 6'b000010;
                    OP_SUB:   ctl = 6'b010011;
                    OP_AND:   ctl = 6'b000000;
                    OP_OR:    ctl = 6'b010101;
                    OP_PASSA: ctl = 6'b001100;
                    default:  ctl = '0;
                endcase
                state_nx = DONE;
            end
            MUL: begin
                bus.alu_x = acc;
                bus.alu_y = mcand;
                // zy forces the y input to zero when this multiplier bit is clear
                ctl = mplier[0] ? 6'b000010 : 6'b001010;
                if (cnt == CNT_LAST) state_nx = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Command capture, multiply iteration state and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            rsp_data_q <= '0;
            rsp_zr_q   <= 1'b0;
            rsp_ng_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q   <= bus.cmd_op;
                        a_q    <= bus.cmd_a;
                        b_q    <= bus.cmd_b;
                        acc    <= '0;
                        mcand  <= bus.cmd_a;
                        mplier <= bus.cmd_b;
                        cnt    <= '0;
                        if (cmd_illegal) begin
                            rsp_data_q <= '0;
                            rsp_zr_q   <= 1'b1;
                            rsp_ng_q   <= 1'b0;
                            rsp_err_q  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    rsp_data_q <= bus.alu_o;
                    rsp_zr_q   <= bus.alu_zr;
                    rsp_ng_q   <= bus.alu_ng;
                    rsp_err_q  <= 1'b0;
                end
                MUL: begin
                    acc    <= bus.alu_o;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        rsp_data_q <= bus.alu_o;
                        rsp_zr_q   <= bus.alu_zr;
                        rsp_ng_q   <= bus.alu_ng;
                        rsp_err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural combinational ALU
// attached to the ALU side of the bus.
module tb_alu_seq_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_seq_ctrl_if #(.WIDTH(16)) bus ();

    alu_seq_ctrl #(.WIDTH(16), .ITERS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU: optional zero/negate on each input, add or and, optional negate.
    logic [15:0] ax, ay, ao;
    always_comb begin
        ax = bus.alu_zx ? 16'h0000 : bus.alu_x;
        if (bus.alu_nx) ax = ~ax;
        ay = bus.alu_zy ? 16'h0000 : bus.alu_y;
        if (bus.alu_ny) ay = ~ay;
        ao = bus.alu_f ? (ax + ay) : (ax & ay);
        if (bus.alu_no) ao = ~ao;
        bus.alu_o  = ao;
        bus.alu_zr = (ao == 16'h0000);
        bus.alu_ng = ao[15];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command, measure latency to rsp_valid and check the response (not consumed).
    task automatic issue(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_data,
                         input logic exp_zr, input logic exp_ng, input logic exp_err,
                         input int exp_lat);
        int lat;
        chk({tag, "_ready_before"}, 16'(bus.cmd_ready), 16'h1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 16'(lat), 16'(exp_lat));
        chk({tag, "_data"}, bus.rsp_data, exp_data);
        chk({tag, "_zr"}, 16'(bus.rsp_zr), 16'(exp_zr));
        chk({tag, "_ng"}, 16'(bus.rsp_ng), 16'(exp_ng));
        chk({tag, "_err"}, 16'(bus.rsp_err), 16'(exp_err));
    endtask

    task automatic consume(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_idle_ready"}, 16'(bus.cmd_ready), 16'h1);
        chk({tag, "_idle_valid"}, 16'(bus.rsp_valid), 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_a     = 16'h0000;
        bus.cmd_b     = 16'h0000;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_cmd_ready", 16'(bus.cmd_ready), 16'h1);
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
        chk("rst_rsp_data", bus.rsp_data, 16'h0000);
        chk("rst_rsp_flags", 16'({bus.rsp_zr, bus.rsp_ng, bus.rsp_err}), 16'h0);
        chk("rst_alu_x", bus.alu_x, 16'h0000);
        chk("rst_alu_y", bus.alu_y, 16'h0000);
        chk("rst_alu_ctl", 16'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}), 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops
        issue("add", 3'b000, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1'b0, 1'b0, 2);
        chk("done_alu_ctl", 16'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}), 16'h0);
        consume("add");
        issue("sub", 3'b001, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1, 1'b0, 2);
        consume("sub");
        issue("and", 3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 2);
        consume("and");
        issue("or", 3'b011, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 2);
        consume("or");
        issue("passa", 3'b100, 16'hABCD, 16'h1111, 16'hABCD, 1'b0, 1'b1, 1'b0, 2);
        consume("passa");
        issue("sub_zero", 3'b001, 16'h7777, 16'h7777, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
        consume("sub_zero");

        // MUL with backpressure and a competing command held on cmd_valid
        issue("mul300x200", 3'b101, 16'd300, 16'd200, 16'hEA60, 1'b0, 1'b1, 1'b0, 17);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b000;
        bus.cmd_a     = 16'h0001;
        bus.cmd_b     = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 16'(bus.rsp_valid), 16'h1);
            chk("bp_cmd_ready", 16'(bus.cmd_ready), 16'h0);
            chk("bp_rsp_data", bus.rsp_data, 16'hEA60);
            chk("bp_rsp_ng", 16'(bus.rsp_ng), 16'h1);
        end
        bus.cmd_valid = 1'b0;
        consume("bp");
        @(posedge clk); #1;
        chk("bp_no_stale_accept", 16'(bus.cmd_ready), 16'h1);

        issue("mul_wrap", 3'b101, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 17);
        consume("mul_wrap");
        issue("mul_ffff", 3'b101, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 17);
        consume("mul_ffff");

        // Illegal opcodes
        issue("ill110", 3'b110, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b1, 1);
        consume("ill110");
        issue("ill111", 3'b111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1);
        consume("ill111");

        // Reset in the middle of a MUL at iteration 8
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b101;
        bus.cmd_a     = 16'd3;
        bus.cmd_b     = 16'd5;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("midmul_busy", 16'(bus.cmd_ready), 16'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_cmd_ready", 16'(bus.cmd_ready), 16'h1);
        chk("midrst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
        chk("midrst_rsp_data", bus.rsp_data, 16'h0000);
        chk("midrst_alu_x", bus.alu_x, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", 16'(seen), 16'h0);

        // Recovery after the aborted MUL
        issue("post_rst_mul", 3'b101, 16'd7, 16'd9, 16'd63, 1'b0, 1'b0, 1'b0, 17);
        consume("post_rst_mul");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
